// File: rtl/frame_scheduler.sv
// LED-matrix frame sequencer: walks pixels through read/load/transmit, then latch gap,
// pads each frame to a fixed period and pulses game_step at frame end.
module frame_scheduler #(
  parameter int NUM_PIXELS     = 64,
  parameter int BITS_PER_PIXEL = 24,
  parameter int CYCLES_PER_BIT = 15,
  parameter int LATCH_CYCLES   = 3600,
  parameter int FRAME_CYCLES   = 375000,
  localparam int PIX_W         = $clog2(NUM_PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             start,
  output logic             load_sreg,
  output logic             transmit_pixel,
  output logic [PIX_W-1:0] pixel,
  output logic             latch,
  output logic             game_step,
  output logic             busy,
  output logic [15:0]      frame_count,
  output logic             overrun
);
  localparam int TX_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;
  localparam int CNT_MAX   = (TX_CYCLES > LATCH_CYCLES) ? TX_CYCLES : LATCH_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int FC_W      = $clog2(FRAME_CYCLES + 1);

  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_SAT   = '1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, TX, LATCH, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FC_W-1:0]  frame_cyc;
  logic             frame_end, ovr_hit;

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    ovr_hit   = 1'b0;
    case (state)
      IDLE:  if (run || start) state_nxt = READ;
      READ:  state_nxt = LOAD;
      LOAD:  state_nxt = TX;
      TX:    if (cnt == TX_LAST) state_nxt = (pixel == PIX_LAST) ? LATCH : READ;
      LATCH: if (cnt == LAT_LAST) begin
               // latch gap already ran past the frame period: end now, flag it
               if (frame_cyc >= FC_LAST) begin
                 frame_end = 1'b1;
                 ovr_hit   = 1'b1;
               end else begin
                 state_nxt = WAIT;
               end
             end
      WAIT:  if (frame_cyc == FC_LAST) frame_end = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (frame_end) state_nxt = run ? READ : IDLE;
  end

  assign load_sreg      = (state == LOAD);
  assign transmit_pixel = (state == TX);
  assign latch          = (state == LATCH);
  assign busy           = (state != IDLE);
  assign game_step      = frame_end;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_cyc   <= '0;
      pixel       <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      // in-state cycle counter, restarted on every state change
      if (state_nxt != state || state == IDLE || state == WAIT) cnt <= '0;
      else                                                       cnt <= cnt + CNT_W'(1);
      if (state == IDLE || frame_end) frame_cyc <= '0;
      else if (frame_cyc != FC_SAT)   frame_cyc <= frame_cyc + FC_W'(1);
      if (frame_end)
        pixel <= '0;
      else if (state == TX && cnt == TX_LAST && pixel != PIX_LAST)
        pixel <= pixel + PIX_W'(1);
      if (frame_end) frame_count <= frame_count + 16'd1;
      if (ovr_hit)   overrun     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with small parameters; expected timing is
// written out from the frame layout (8-cycle pixels, 5-cycle latch, 40-cycle frame).
module tb_frame_scheduler;
  logic        clk, rst, run, start, run2, start2;
  logic        load_sreg, transmit_pixel, latch, game_step, busy, overrun;
  logic [1:0]  pixel;
  logic [15:0] frame_count;
  logic        load_sreg2, transmit_pixel2, latch2, game_step2, busy2, overrun2;
  logic [1:0]  pixel2;
  logic [15:0] frame_count2;

  int n_chk  = 0;
  int n_fail = 0;

  frame_scheduler #(.NUM_PIXELS(4), .BITS_PER_PIXEL(2), .CYCLES_PER_BIT(3),
                    .LATCH_CYCLES(5), .FRAME_CYCLES(40)) dut (
    .clk(clk), .rst(rst), .run(run), .start(start),
    .load_sreg(load_sreg), .transmit_pixel(transmit_pixel), .pixel(pixel),
    .latch(latch), .game_step(game_step), .busy(busy),
    .frame_count(frame_count), .overrun(overrun));

  frame_scheduler #(.NUM_PIXELS(4), .BITS_PER_PIXEL(2), .CYCLES_PER_BIT(3),
                    .LATCH_CYCLES(5), .FRAME_CYCLES(30)) dut_ov (
    .clk(clk), .rst(rst), .run(run2), .start(start2),
    .load_sreg(load_sreg2), .transmit_pixel(transmit_pixel2), .pixel(pixel2),
    .latch(latch2), .game_step(game_step2), .busy(busy2),
    .frame_count(frame_count2), .overrun(overrun2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {25'b0, busy, load_sreg, transmit_pixel, latch, game_step, pixel};
  endfunction

  // expected {busy,load,tx,latch,game_step,pixel} at frame cycle k (FRAME_CYCLES=40)
  function automatic logic [31:0] model(input int k, input bit cont);
    int kk;
    logic b, ld, tx, la, gs;
    logic [1:0] px;
    kk = cont ? (k % 40) : k;
    b = 0; ld = 0; tx = 0; la = 0; gs = 0; px = 2'd0;
    if (kk < 40) b = 1;
    if (kk < 32) begin
      px = 2'(kk / 8);
      ld = (kk % 8) == 1;
      tx = (kk % 8) >= 2;
    end else if (kk < 40) begin
      px = 2'd3;
    end
    la = (kk >= 32) && (kk <= 36);
    gs = (kk == 39);
    return {25'b0, b, ld, tx, la, gs, px};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; run = 0; start = 0; run2 = 0; start2 = 0;
    repeat (3) @(posedge clk);
    check("rst_vec", obs_vec(), 32'h0);
    check("rst_fc", 32'(frame_count), 32'h0);
    check("rst_ov", 32'(overrun), 32'h0);
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      check($sformatf("idle_c%0d", k), obs_vec(), 32'h0);
    end
    check("idle_fc", 32'(frame_count), 32'h0);

    // one-shot frame
    start = 1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      check($sformatf("shot_c%0d", k), obs_vec(), model(k, 0));
      start = 0;
    end
    check("shot_fc", 32'(frame_count), 32'd1);
    check("shot_ov", 32'(overrun), 32'd0);

    // three back-to-back frames, run dropped on the third game_step cycle
    run = 1;
    for (int k = 0; k < 123; k++) begin
      @(posedge clk);
      check($sformatf("run_c%0d", k), obs_vec(), model(k, k < 120));
      if (k == 119) run = 0;
    end
    check("run_fc", 32'(frame_count), 32'd4);
    check("run_ov", 32'(overrun), 32'd0);

    // run+start together, run dropped at 12, stray start mid-frame
    run = 1; start = 1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      check($sformatf("drop_c%0d", k), obs_vec(), model(k, 0));
      if (k == 0)  start = 0;
      if (k == 12) run = 0;
      if (k == 20) start = 1;
      if (k == 21) start = 0;
    end
    check("drop_fc", 32'(frame_count), 32'd5);

    // frame period shorter than minimum frame: overrun instance
    run2 = 1;
    for (int k = 0; k < 116; k++) begin
      @(posedge clk);
      check($sformatf("ovr_c%0d", k), {29'b0, busy2, game_step2, overrun2},
            {29'b0, 1'(k <= 110), 1'(k == 36 || k == 73 || k == 110), 1'(k >= 37)});
      if (k == 37) check("ovr_read", {30'b0, load_sreg2, 1'b0}, 32'h0);
      if (k == 38) check("ovr_load", {30'b0, load_sreg2, 1'b0}, 32'h2);
      if (k == 80) run2 = 0;
    end
    check("ovr_fc", 32'(frame_count2), 32'd3);
    check("ovr_sticky", 32'(overrun2), 32'd1);

    // async reset in the middle of pixel 2 transmit
    start = 1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      check($sformatf("abort_c%0d", k), obs_vec(), model(k, 0));
      start = 0;
    end
    #2 rst = 1;
    #1;
    check("abort_vec", obs_vec(), 32'h0);
    check("abort_fc", 32'(frame_count), 32'd0);
    check("abort_ov2", 32'(overrun2), 32'd0);
    @(posedge clk);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      check($sformatf("post_c%0d", k), obs_vec(), 32'h0);
    end
    check("post_fc", 32'(frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
